// File: rtl/video_pixel_pack_if.sv
// ----------------------------------------------------------------------------
// video_pixel_pack_if
//   Pixel-in / word-out handshake bundle for the pixel packer.
//   master : pixel producer and word consumer (capture path, pattern writer)
//   slave  : the packer itself
//   Signals:
//     bpp_mode  [2:0]  0=1bpp 1=2bpp 2=4bpp 3=8bpp 4=16bpp, 5-7 -> 16bpp
//     in_pixel  [15:0] pixel value, low bpp bits used
//     in_valid/in_ready/in_last   pixel handshake, last flushes partial word
//     out_data  [31:0] packed word
//     out_valid/out_ready/out_last word handshake, last = closed by in_last
// ----------------------------------------------------------------------------
interface video_pixel_pack_if;
   logic [2:0]  bpp_mode;
   logic [15:0] in_pixel;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output bpp_mode, in_pixel, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_last, out_valid
   );

   modport slave (
      input  bpp_mode, in_pixel, in_valid, in_last, out_ready,
      output in_ready, out_data, out_last, out_valid
   );
endinterface

// File: rtl/video_pixel_pack.sv
// ----------------------------------------------------------------------------
// video_pixel_pack
//   Packs a 1/2/4/8/16 bpp pixel stream LSB-first into 32-bit words; pixel i
//   of a word lands in bits [i*bpp +: bpp], mirroring the scan-out demux.
//   One accumulating word plus one output holding register sustain one pixel
//   per cycle; when the output is stalled, a closed word parks in the
//   accumulator and the pixel side stalls until the output drains.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    video_pixel_pack_if.slave (pixel in, word out handshakes)
// ----------------------------------------------------------------------------
module video_pixel_pack (
   input  logic                clk,
   input  logic                reset,
   video_pixel_pack_if.slave   bus
);

   // S_FILL: accumulator is collecting pixels.
   // S_HELD: accumulator holds a closed word waiting for the output slot.
   typedef enum logic {S_FILL, S_HELD} st_t;

   st_t         state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic        acc_last_q, acc_last_d;
   logic [4:0]  idx_q, idx_d;
   logic [2:0]  mode_q, mode_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic        out_valid_q, out_valid_d;

   logic [2:0]  mode_sel;      // sanitised bpp_mode input
   logic [2:0]  mode_cur;      // mode governing the pixel being offered
   logic [15:0] pix_mask;
   logic [4:0]  pix_last_idx;  // pixels-per-word minus one
   logic [4:0]  shamt;
   logic [31:0] pix_word;
   logic [31:0] acc_merge;
   logic        accept;
   logic        close;
   logic        slot_free;

   // Mode decode: the first pixel of a word uses the live input, the rest of
   // the word reuses the mode latched with that first pixel.
   always_comb begin
      mode_sel = (bus.bpp_mode > 3'd4) ? 3'd4 : bus.bpp_mode;
      mode_cur = (idx_q == 5'd0) ? mode_sel : mode_q;
      case (mode_cur)
         3'd0:    begin pix_mask = 16'h0001; pix_last_idx = 5'd31; end
         3'd1:    begin pix_mask = 16'h0003; pix_last_idx = 5'd15; end
         3'd2:    begin pix_mask = 16'h000F; pix_last_idx = 5'd7;  end
         3'd3:    begin pix_mask = 16'h00FF; pix_last_idx = 5'd3;  end
         default: begin pix_mask = 16'hFFFF; pix_last_idx = 5'd1;  end
      endcase
   end

   // idx*bpp never exceeds 31 for a legal idx, so 5 bits suffice.
   assign shamt     = idx_q << mode_cur;
   assign pix_word  = {16'h0000, bus.in_pixel & pix_mask} << shamt;
   assign acc_merge = acc_q | pix_word;

   assign accept    = bus.in_valid && (state_q == S_FILL);
   assign close     = accept && ((idx_q == pix_last_idx) || bus.in_last);
   assign slot_free = !out_valid_q || bus.out_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      acc_last_d  = acc_last_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !bus.out_ready;

      case (state_q)
         S_FILL: begin
            if (accept) begin
               if (idx_q == 5'd0)
                  mode_d = mode_sel;
               if (close) begin
                  idx_d = 5'd0;
                  if (slot_free) begin
                     // Closed word goes straight to the output slot.
                     out_data_d  = acc_merge;
                     out_last_d  = bus.in_last;
                     out_valid_d = 1'b1;
                     acc_d       = 32'h0;
                     acc_last_d  = 1'b0;
                  end else begin
                     // Slot busy: park the word, stall the pixel side.
                     acc_d      = acc_merge;
                     acc_last_d = bus.in_last;
                     state_d    = S_HELD;
                  end
               end else begin
                  acc_d = acc_merge;
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_HELD: begin
            if (slot_free) begin
               out_data_d  = acc_q;
               out_last_d  = acc_last_q;
               out_valid_d = 1'b1;
               acc_d       = 32'h0;
               acc_last_d  = 1'b0;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FILL;
         acc_q       <= 32'h0;
         acc_last_q  <= 1'b0;
         idx_q       <= 5'd0;
         mode_q      <= 3'd0;
         out_data_q  <= 32'h0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         acc_last_q  <= acc_last_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready comes straight from the state register: no path from out_ready.
   assign bus.in_ready  = (state_q == S_FILL);
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_video_pixel_pack.sv
// ----------------------------------------------------------------------------
// tb_video_pixel_pack
//   Directed scenarios plus a randomized run against a word-level reference
//   model (pixel lists turned into words by arithmetic) and an output
//   scoreboard that also watches for data changing under backpressure.
// ----------------------------------------------------------------------------
module tb_video_pixel_pack;

   logic clk;
   logic reset;
   video_pixel_pack_if bus();

   video_pixel_pack dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_words = 0;
   bit rnd_en = 1'b0;

   // ---------------- reference model + scoreboard ----------------
   logic [32:0] exp_q[$];      // {last, word}
   int          m_cnt = 0;
   int          m_bpp = 1;
   logic [31:0] m_word = 32'h0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   logic [32:0] e;
   logic [31:0] pv;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_cnt = 0;
         m_word = 32'h0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            n_cmp++;
            if (bus.out_data !== prev_data || bus.out_last !== prev_last) begin
               n_bad++;
               $display("FAIL hold_stable: got %h/%b want %h/%b", bus.out_data, bus.out_last, prev_data, prev_last);
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_data = bus.out_data;
         prev_last = bus.out_last;

         if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            n_words++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL scoreboard_extra: got %h with no word expected", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               if ({bus.out_last, bus.out_data} !== e) begin
                  n_bad++;
                  $display("FAIL scoreboard_word: got %h last=%b want %h last=%b", bus.out_data, bus.out_last, e[31:0], e[32]);
               end
            end
         end

         if (bus.in_valid && bus.in_ready) begin
            if (m_cnt == 0)
               m_bpp = (bus.bpp_mode > 3'd4) ? 16 : (1 << bus.bpp_mode);
            pv = 32'(bus.in_pixel) & ((32'd1 << m_bpp) - 32'd1);
            m_word = m_word | (pv << (m_cnt * m_bpp));
            m_cnt++;
            if (m_cnt == 32 / m_bpp || bus.in_last) begin
               exp_q.push_back({bus.in_last, m_word});
               m_cnt = 0;
               m_word = 32'h0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [2:0] m, input logic [15:0] p, input logic l);
      int t;
      bus.bpp_mode = m;
      bus.in_pixel = p;
      bus.in_last  = l;
      bus.in_valid = 1'b1;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 500) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready=%b want 1 within 500 cycles", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
      n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_8bpp();
      bus.out_ready = 1'b1;
      send(3'd3, 16'h0011, 1'b0);
      send(3'd3, 16'h0022, 1'b0);
      send(3'd3, 16'h0033, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b8_early_valid: got %b want 0", bus.out_valid); end
      send(3'd3, 16'h0044, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b8_valid: got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 32'h44332211) begin n_bad++; $display("FAIL b8_data: got %h want 44332211", bus.out_data); end
      n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL b8_last: got %b want 0", bus.out_last); end
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b8_one_cycle: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_1bpp();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 32; i++)
         send(3'd0, (i % 2 == 0) ? 16'hFFFF : 16'hFFFE, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55555555) begin
         n_bad++; $display("FAIL b1_word: got %h valid=%b want 55555555 valid=1", bus.out_data, bus.out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_4bpp_last();
      bus.out_ready = 1'b1;
      send(3'd2, 16'h000A, 1'b0);
      send(3'd2, 16'h000B, 1'b0);
      send(3'd2, 16'h000C, 1'b1);
      n_cmp++; if (bus.out_data !== 32'h00000CBA || bus.out_last !== 1'b1) begin
         n_bad++; $display("FAIL b4_flush: got %h last=%b want 00000cba last=1", bus.out_data, bus.out_last);
      end
      send(3'd2, 16'h0007, 1'b0);
      send(3'd2, 16'h0008, 1'b1);
      n_cmp++; if (bus.out_data !== 32'h00000087 || bus.out_last !== 1'b1) begin
         n_bad++; $display("FAIL b4_restart: got %h last=%b want 00000087 last=1", bus.out_data, bus.out_last);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_16bpp_backpressure();
      bus.out_ready = 1'b0;
      send(3'd4, 16'h1234, 1'b0);
      send(3'd4, 16'h5678, 1'b0);
      send(3'd4, 16'h9ABC, 1'b0);
      send(3'd4, 16'hDEF0, 1'b0);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL b16_stall: in_ready got %b want 0", bus.in_ready); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h56781234) begin
         n_bad++; $display("FAIL b16_held: got %h valid=%b want 56781234 valid=1", bus.out_data, bus.out_valid);
      end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL b16_still_stalled: got %b want 0", bus.in_ready); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEF09ABC) begin
         n_bad++; $display("FAIL b16_second: got %h valid=%b want def09abc valid=1", bus.out_data, bus.out_valid);
      end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b16_resume: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b16_drained: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_mode_switch();
      bus.out_ready = 1'b1;
      send(3'd1, 16'h0001, 1'b0);
      send(3'd1, 16'h0002, 1'b0);
      send(3'd1, 16'h0003, 1'b0);
      for (int i = 0; i < 13; i++)
         send(3'd3, 16'h0000, 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000039) begin
         n_bad++; $display("FAIL mode_latch: got %h valid=%b want 00000039 valid=1", bus.out_data, bus.out_valid);
      end
      send(3'd3, 16'h00AA, 1'b0);
      send(3'd3, 16'h00BB, 1'b0);
      send(3'd3, 16'h00CC, 1'b0);
      send(3'd3, 16'h00DD, 1'b0);
      n_cmp++; if (bus.out_data !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL mode_next: got %h want ddccbbaa", bus.out_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         send(3'd3, 16'(8'hF0 + i), 1'b0);
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      send(3'd3, 16'h0001, 1'b0);
      send(3'd3, 16'h0002, 1'b0);
      send(3'd3, 16'h0003, 1'b0);
      send(3'd3, 16'h0004, 1'b0);
      n_cmp++; if (bus.out_data !== 32'h04030201 || bus.out_last !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid_clean: got %h last=%b want 04030201 last=0", bus.out_data, bus.out_last);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int stalls;
      stalls = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.in_ready !== 1'b1) stalls++;
         send(3'd4, 16'($urandom), 1'b0);
      end
      n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int t;
      int w0;
      w0 = n_words;
      rnd_en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send(3'($urandom_range(0, 7)), 16'($urandom), (i == 599) || ($urandom_range(0, 9) == 0));
      end
      rnd_en = 1'b0;
      @(posedge clk); #2;
      bus.out_ready = 1'b1;
      t = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      n_cmp++; if (t >= 300) begin n_bad++; $display("FAIL rnd_drain: %0d words left, want 0", exp_q.size()); end
      n_cmp++; if (n_words - w0 < 20) begin n_bad++; $display("FAIL rnd_words: got %0d words want >= 20", n_words - w0); end
   endtask

   initial begin
      reset         = 1'b1;
      bus.bpp_mode  = 3'd0;
      bus.in_pixel  = 16'h0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_8bpp();
      test_1bpp();
      test_4bpp_last();
      test_16bpp_backpressure();
      test_mode_switch();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/video_pixel_pack.md
Name: video_pixel_pack

Overview:
- Inverse of the scan-out pixel demultiplexer: accepts a stream of pixels at 1/2/4/8/16 bpp and packs them LSB-first into 32-bit words, ready for writing back to frame memory (capture path, test-pattern writer).
- Bit placement matches the demux exactly: pixel i of a word occupies bits [i*bpp +: bpp].
- Valid/ready handshakes on both sides; one accumulating word plus one output holding register, so 1 pixel/cycle is sustained.

Parameters:
- none (word width fixed at 32, pixel bus fixed at 16)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bpp_mode  in  3  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp, 4=16bpp; 5-7 treated as 16bpp
- in_pixel  in  16  pixel value; only low bpp bits used, upper bits ignored
- in_valid  in  1  pixel present
- in_last  in  1  pixel is last of line/burst; flushes partial word
- in_ready  out  1  pixel accepted when in_valid && in_ready
- out_data  out  32  packed word
- out_last  out  1  word was closed by in_last
- out_valid  out  1  word present
- out_ready  in  1  word consumed when out_valid && out_ready

Behaviour:
- Reset (async assert, sync release): acc=0, idx=0, acc_full=0, out_valid=0, out_data=0, out_last=0, in_ready=1. A partial word or held word is discarded.
- Pixels per word N = 32/bpp: 32, 16, 8, 4, 2.
- Mode latch: bpp_mode is sampled on acceptance of the first pixel of a word (idx==0) and held until that word closes. Changes mid-word take effect at the next word.
- Accept: write pixel bits to acc[idx*bpp +: bpp]; idx++. Unwritten bits of a word are 0.
- Word close: the accepted pixel has idx==N-1, or in_last=1, or both. In all cases exactly one word is produced; out_last = in_last of the closing pixel. After close: acc=0, idx=0.
- Transfer: if the output slot is empty, or drains in the same cycle (out_valid && out_ready), the closed word loads out_data/out_last. out_valid=1 on the next cycle, giving 1-cycle latency from the closing accept.
- If the slot is occupied and not draining, the closed word stays in acc and acc_full=1. in_ready is deasserted the following cycle. When the slot drains, acc transfers, acc_full clears, and in_ready=1 again.
- in_ready = !acc_full. It is registered, so there is no combinational path from out_ready. No pixel is dropped or duplicated under any backpressure pattern.
- out_data and out_last are stable while out_valid && !out_ready.
- Ordering: words leave strictly in close order.
- Throughput: with out_ready=1, one pixel per cycle indefinitely, including 16bpp (a word every 2 cycles).
- in_last with no pixels pending is impossible (in_last rides on a pixel). in_last on the first pixel produces a word holding that one pixel.

Test Plan:
- 8bpp, out_ready=1; pixels 0x11,0x22,0x33,0x44 on consecutive cycles -> out_data=0x44332211, out_last=0, out_valid exactly 1 cycle after 4th accept.
- 1bpp; 32 pixels alternating 1,0 starting with 1 (in_pixel upper bits =0xFFFE garbage) -> single word 0x55555555.
- 4bpp; pixels 0xA,0xB,0xC with in_last on third -> 0x00000CBA, out_last=1. Next word starts at idx 0.
- 16bpp, out_ready=0; pixels 0x1234,0x5678,0x9ABC,0xDEF0 -> out_data 0x56781234 held, in_ready=0 after 4th accept. Raise out_ready -> words 0x56781234 then 0xDEF09ABC, no loss, in_ready returns to 1.
- Mode switch 2bpp->8bpp after 3 pixels (1,2,3) then 13 more 2bpp-width accepts of 0 -> first word 0x00000039 built at 2bpp. Following pixels pack at 8bpp.
- Assert reset mid-word (8bpp, 2 pixels in) and with a held output word -> out_valid=0 immediately, in_ready=1. Next 4 pixels form a clean word with no stale bits.
